// File: rtl/bus_protocol_arbiter_if.sv
// Shared transfer bus between the arbiter (master) and the bus target (slave).
// Carries dValid/data from the master and dAck back from the target.
interface bus_protocol_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    logic              dValid;
    logic [DATA_W-1:0] data;
    logic              dAck;

    modport master (output dValid, output data, input dAck);
    modport slave  (input dValid, input data, output dAck);
endinterface

// File: rtl/bus_protocol_arbiter.sv
// Shares one dValid/dAck/data bus between NUM_REQ requesters with round-robin arbitration.
// Define BUS_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module bus_protocol_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_VALID = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          err,
    output logic                        busy,
    bus_protocol_arbiter_if.master      bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_VALID + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                dvalid_q, dvalid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;

    logic [IDX_W-1:0]    win_c;
    logic [DATA_W-1:0]   win_data_c;

    // Winner selection among currently active requests
    always_comb begin
        win_c = '0;
`ifdef BUS_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDX_W'(k)]) win_c = IDX_W'(k);
        end
`else
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (req[IDX_W'(idx)]) win_c = IDX_W'(idx);
        end
`endif
        win_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_c == IDX_W'(i)) win_data_c = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state and output logic; dAck is ignored on the first dValid cycle
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        vcnt_d   = vcnt_q;
        gnt_d    = gnt_q;
        dvalid_d = dvalid_q;
        data_d   = data_q;
        done_d   = '0;
        err_d    = '0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = NUM_REQ'(1) << win_c;
                    data_d   = win_data_c;
                    dvalid_d = 1'b1;
                    vcnt_d   = CNT_W'(1);
                    rr_ptr_d = win_c;
                    win_d    = win_c;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (vcnt_q == CNT_W'(1)) begin
                    vcnt_d = CNT_W'(2);
                end else if (bus.dAck) begin
                    dvalid_d      = 1'b0;
                    gnt_d         = '0;
                    done_d[win_q] = 1'b1;
                    vcnt_d        = '0;
                    state_d       = IDLE;
                end else if (vcnt_q == CNT_W'(MAX_VALID)) begin
                    dvalid_d     = 1'b0;
                    gnt_d        = '0;
                    err_d[win_q] = 1'b1;
                    vcnt_d       = '0;
                    state_d      = IDLE;
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == XFER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            win_q    <= '0;
            vcnt_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            dvalid_q <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            vcnt_q   <= vcnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dvalid_q <= dvalid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign bus.dValid = dvalid_q;
    assign bus.data   = data_q;

endmodule

// File: tb/tb_bus_protocol_arbiter.sv
// Directed bench for bus_protocol_arbiter: handshake timing, arbitration order, timeout, reset.
module tb_bus_protocol_arbiter;

`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  byte_v [4];
    logic [31:0] req_data;
    logic [3:0]  gnt, done, err;
    logic        busy;
    logic [3:0]  tb_cnt;
    logic [3:0]  ack_at;
    logic        ack_const;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    bus_protocol_arbiter_if #(.DATA_W(8)) bus ();

    bus_protocol_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_VALID(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .bus      (bus)
    );

    assign req_data = {byte_v[3], byte_v[2], byte_v[1], byte_v[0]};

    // Target: acks on dValid cycle number ack_at, or constantly when ack_const
    always @(posedge clk) tb_cnt <= (bus.dValid === 1'b1) ? tb_cnt + 4'd1 : 4'd0;
    assign bus.dAck = ack_const |
                      ((ack_at != 4'd0) && (bus.dValid === 1'b1) && (tb_cnt + 4'd1 == ack_at));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a transfer and checks it cycle by cycle, then the completion cycle
    task automatic run_xfer(input string tag, input int idx, input logic [7:0] exp_data,
                            input int len, input bit ack_ok);
        int gap;
        logic [3:0] g;
        gap = 0;
        g = 4'b0001 << idx;
        for (int w = 0; w < 20 && bus.dValid !== 1'b1; w++) begin
            gap++;
            tick();
        end
        chk({tag, "_start"}, 32'(bus.dValid), 32'd1);
        chk({tag, "_gap"}, 32'(gap >= 1), 32'd1);
        for (int i = 0; i < len; i++) begin
            chk({tag, "_dvalid"}, 32'(bus.dValid), 32'd1);
            chk({tag, "_gnt"}, 32'(gnt), 32'(g));
            chk({tag, "_data"}, 32'(bus.data), 32'(exp_data));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nopulse"}, 32'(done | err), 32'd0);
            tick();
        end
        chk({tag, "_end_dvalid"}, 32'(bus.dValid), 32'd0);
        chk({tag, "_end_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), ack_ok ? 32'(g) : 32'd0);
        chk({tag, "_err"}, 32'(err), ack_ok ? 32'd0 : 32'(g));
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int order [5];
        logic [7:0] tab [4];
        order = '{0, 1, 2, 3, 0};
        tab   = '{8'h10, 8'h20, 8'h30, 8'h40};
        reset = 1'b1;
        req = 4'b0000;
        ack_at = 4'd0;
        ack_const = 1'b0;
        for (int i = 0; i < 4; i++) byte_v[i] = 8'h00;
        tick(); tick(); tick();

        chk("rst_dvalid", 32'(bus.dValid), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done_err", 32'(done | err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_dvalid", 32'(bus.dValid), 32'd0);

        // Single transfer, ack on 2nd dValid cycle
        byte_v[0] = 8'hA5;
        ack_at = 4'd2;
        req = 4'b0001;
        run_xfer("t1", 0, 8'hA5, 2, 1'b1);
        req = 4'b0000;

        // All four requesting, ack on 3rd cycle
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) byte_v[i] = tab[i];
        ack_at = 4'd3;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_xfer("t2", FIXED ? 0 : order[n], FIXED ? 8'h10 : tab[order[n]], 3, 1'b1);
        end

        // Constant dAck: first-cycle ack ignored, every transfer 2 cycles
        byte_v[0] = 8'h11;
        byte_v[1] = 8'h22;
        req = 4'b0011;
        ack_at = 4'd0;
        ack_const = 1'b1;
        run_xfer("t3a", FIXED ? 0 : 1, FIXED ? 8'h11 : 8'h22, 2, 1'b1);
        run_xfer("t3b", 0, 8'h11, 2, 1'b1);
        run_xfer("t3c", FIXED ? 0 : 1, FIXED ? 8'h11 : 8'h22, 2, 1'b1);
        req = 4'b0000;
        tick(); tick();
        chk("idle_ack_dvalid", 32'(bus.dValid), 32'd0);
        chk("idle_ack_done", 32'(done), 32'd0);

        // Target never acks: timeout after MAX_VALID cycles
        ack_const = 1'b0;
        byte_v[2] = 8'h3C;
        req = 4'b0100;
        run_xfer("t4", 2, 8'h3C, 4, 1'b0);
        req = 4'b0000;
        tick();

        // Reset on the 2nd dValid cycle of a transfer from req[1]
        byte_v[1] = 8'h77;
        req = 4'b0010;
        for (int w = 0; w < 20 && bus.dValid !== 1'b1; w++) tick();
        chk("t5_gnt", 32'(gnt), 32'h2);
        chk("t5_data", 32'(bus.data), 32'h77);
        tick();
        chk("t5_second", 32'(bus.dValid), 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_rst_dvalid", 32'(bus.dValid), 32'd0);
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_done_err", 32'(done | err), 32'd0);
        reset = 1'b0;
        byte_v[0] = 8'h5A;
        ack_at = 4'd2;
        req = 4'b0011;
        run_xfer("t5_after", 0, 8'h5A, 2, 1'b1);

        // Two requesters held: alternate (round-robin) or req[0] always (fixed)
        run_xfer("t6a", FIXED ? 0 : 1, FIXED ? 8'h5A : 8'h77, 2, 1'b1);
        run_xfer("t6b", 0, 8'h5A, 2, 1'b1);
        run_xfer("t6c", FIXED ? 0 : 1, FIXED ? 8'h5A : 8'h77, 2, 1'b1);
        req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_protocol_arbiter.md
Name: bus_protocol_arbiter

Overview:
- Round-robin master-side controller that shares one dValid/dAck/data transfer bus between NUM_REQ requesters.
- Latches the winning requester's byte and drives dValid/data so every transfer obeys the bus rules:
  - dValid high for 2..4 clocks;
  - data known and stable while dValid is high;
  - dValid low the clock after dAck.
- Sits between local requesters and the bus target. Reports per-requester completion and timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, bus data width.
- MAX_VALID, 4, maximum consecutive dValid cycles before forced termination.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester transfer request, level.
- req_data  input  NUM_REQ*DATA_W  per-requester byte; slice i = bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant, held for the whole transfer.
- done  output  NUM_REQ  one-clock pulse: transfer acknowledged.
- err  output  NUM_REQ  one-clock pulse: transfer timed out without dAck.
- dValid  output  1  bus data-valid.
- data  output  DATA_W  bus data.
- dAck  input  1  target acknowledge.
- busy  output  1  high while state is XFER.

Behaviour:
- Reset values, applied at the next posedge while reset=1:
  - state=IDLE; dValid=0; data=0; gnt=0; done=0; err=0; busy=0; vcnt=0.
  - rr_ptr=NUM_REQ-1, so req[0] wins first.
- Reset mid-transfer: dValid drops at the same edge. No done/err pulse is produced.
- All outputs are registered.
- IDLE:
  - If req!=0, select the winner from the round-robin search starting at rr_ptr+1 (mod NUM_REQ).
  - At that edge: gnt<=onehot(winner), data<=req_data[winner], dValid<=1, vcnt<=1, rr_ptr<=winner, state<=XFER.
  - If req==0, hold all outputs idle.
- XFER, evaluated each posedge with dValid=1:
  - vcnt==1 (first dValid cycle): dAck is ignored, because a target may not ack there. Then vcnt<=2.
  - vcnt>=2 and dAck=1: dValid<=0, gnt<=0, done[winner]<=1, state<=IDLE.
  - vcnt==MAX_VALID and dAck=0: dValid<=0, gnt<=0, err[winner]<=1, state<=IDLE.
  - Otherwise: vcnt<=vcnt+1.
- Guarantees that follow:
  - dValid is high between 2 and MAX_VALID clocks.
  - dValid is low the clock after an accepted dAck.
  - dValid is low for at least one clock between transfers, since IDLE lasts one cycle minimum. Back-to-back transfers therefore start every (len+1) cycles.
- data changes only at the IDLE->XFER edge and is stable through XFER. It holds its last value in IDLE.
- A requester may drop req or change req_data during its transfer. Neither affects the transfer in progress.
- A requester that is still requesting after done/err re-enters arbitration behind the others.
- dAck while in IDLE is ignored.
- done and err are never asserted together and are zero outside their single cycle.
- rr_ptr wraps NUM_REQ-1 -> 0.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index active req always wins and rr_ptr is not used. All bus timing rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset then req=4'b0001, req_data[0]=8'hA5, target acks on 2nd dValid cycle:
  - dValid high exactly 2 clocks with data=A5;
  - gnt=0001 during the transfer;
  - done[0] pulse the clock after dAck;
  - dValid=0 that same clock.
- req=4'b1111, data 8'h10/8'h20/8'h30/8'h40, target acks on 3rd cycle:
  - grants in order 0,1,2,3,0;
  - at least one dValid=0 cycle between transfers;
  - data bytes match the granted requester.
- Target holds dAck=1 constantly:
  - dAck in the first dValid cycle is ignored;
  - every transfer is exactly 2 dValid cycles.
- Target never acks, req=4'b0100, req_data[2]=8'h3C:
  - dValid high exactly 4 clocks;
  - err[2] pulses;
  - done stays 0;
  - dValid low the next clock.
- reset asserted on the 2nd dValid cycle of a transfer from req[1]:
  - dValid, gnt, done and err all 0 at the next edge;
  - after reset release with req=4'b0011, req[0] is granted first.
- Build with BUS_ARB_FIXED_PRIO_EN, req=4'b0011 held:
  - req[0] is granted on every transfer;
  - req[1] is never granted while req[0] stays high.
